// File: rtl/cpu_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_sequencer_if
//  Description : CPU bus timing bundle between the PHI2/strobe sequencer and
//                the ICD, address decoder and SRAM/IO bus drivers.
//  Signals     : stop_req  - ICD level request to halt at next cycle boundary
//                step_req  - ICD one-clk pulse, run one cycle while stopped
//                cpu_rwn   - CPU R/W (1 = read)
//                cs_en     - decoder: address targets the SRAM/IO bus
//                cphi2     - CPU PHI2 clock
//                addr_stb  - one-clk pulse, CPU address is stable
//                mem_rdn   - memory read strobe, active-low
//                mem_wrn   - memory write strobe, active-low
//                rd_latch  - one-clk pulse, capture read data
//                cycle_end - one-clk pulse on last tick of an executed cycle
//                stopped   - CPU frozen with PHI2 low
//  Modports    : master - the sequencer (drives PHI2 and strobes)
//                slave  - the environment (drives requests and CPU status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_bus_sequencer_if;
   logic stop_req;
   logic step_req;
   logic cpu_rwn;
   logic cs_en;
   logic cphi2;
   logic addr_stb;
   logic mem_rdn;
   logic mem_wrn;
   logic rd_latch;
   logic cycle_end;
   logic stopped;

   modport master (
      input  stop_req, step_req, cpu_rwn, cs_en,
      output cphi2, addr_stb, mem_rdn, mem_wrn, rd_latch, cycle_end, stopped
   );

   modport slave (
      output stop_req, step_req, cpu_rwn, cs_en,
      input  cphi2, addr_stb, mem_rdn, mem_wrn, rd_latch, cycle_end, stopped
   );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_sequencer
//  Description : Divides the FPGA clock into fixed-length 65C02 bus cycles,
//                generating PHI2 and the SRAM/IO strobe timing. Supports ICD
//                stop and single-step by freezing PHI2 low between cycles.
//  Ports       : clk    - FPGA system clock (rising edge)
//                resetn - synchronous reset, active-low
//                bus    - cpu_bus_sequencer_if.master (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_sequencer #(
   parameter int LOW_TICKS  = 4,
   parameter int HIGH_TICKS = 4,
   parameter int ADDR_TICK  = 2,
   parameter int WR_DLY     = 1
) (
   input  wire logic             clk,
   input  wire logic             resetn,
   cpu_bus_sequencer_if.master   bus
);

   localparam int PERIOD = LOW_TICKS + HIGH_TICKS;
   localparam int CW     = $clog2(PERIOD);

   localparam logic [CW-1:0] c_one      = CW'(1);
   localparam logic [CW-1:0] c_addr     = CW'(ADDR_TICK);
   localparam logic [CW-1:0] c_low      = CW'(LOW_TICKS);
   localparam logic [CW-1:0] c_wr_first = CW'(LOW_TICKS + WR_DLY);
   localparam logic [CW-1:0] c_wr_last  = CW'(PERIOD - 2);
   localparam logic [CW-1:0] c_last     = CW'(PERIOD - 1);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_STOP = 1'b1
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_rw_lat;
   logic          r_cs_lat;

   logic r_cphi2, r_addr_stb, r_mem_rdn, r_mem_wrn;
   logic r_rd_latch, r_cycle_end, r_stopped;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_rw_nxt;
   logic          w_cs_nxt;
   logic          w_run_nxt;

   // Next-state logic. Outputs are decoded from the next values below so that
   // every output register changes on the same edge as the counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rw_nxt    = r_rw_lat;
      w_cs_nxt    = r_cs_lat;

      if (r_state == S_RUN) begin
         if (r_cnt == c_last) begin
            // Cycle boundary: the only point where stop_req is honoured.
            w_cnt_nxt = '0;
            if (bus.stop_req) begin
               w_state_nxt = S_STOP;
            end
         end else begin
            w_cnt_nxt = r_cnt + c_one;
         end
      end else begin
         w_cnt_nxt = '0;
         // A step pulse runs one cycle; if stop_req is still high it re-enters
         // STOP at the next boundary through the RUN branch above.
         if (!bus.stop_req || bus.step_req) begin
            w_state_nxt = S_RUN;
         end
      end

      w_run_nxt = (w_state_nxt == S_RUN);

      // Capture R/W and chip-select on the edge that raises addr_stb.
      if (w_run_nxt && (w_cnt_nxt == c_addr)) begin
         w_rw_nxt = bus.cpu_rwn;
         w_cs_nxt = bus.cs_en;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_RUN;
         r_cnt       <= '0;
         r_rw_lat    <= 1'b1;
         r_cs_lat    <= 1'b0;
         r_cphi2     <= 1'b0;
         r_addr_stb  <= 1'b0;
         r_mem_rdn   <= 1'b1;
         r_mem_wrn   <= 1'b1;
         r_rd_latch  <= 1'b0;
         r_cycle_end <= 1'b0;
         r_stopped   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rw_lat    <= w_rw_nxt;
         r_cs_lat    <= w_cs_nxt;
         r_cphi2     <= w_run_nxt && (w_cnt_nxt >= c_low);
         r_addr_stb  <= w_run_nxt && (w_cnt_nxt == c_addr);
         // Read strobe stays low through the last tick and releases with
         // the PHI2 fall when the counter wraps.
         r_mem_rdn   <= !(w_run_nxt && w_cs_nxt && w_rw_nxt && (w_cnt_nxt > c_addr));
         // Write strobe releases one tick before PHI2 falls for data hold.
         r_mem_wrn   <= !(w_run_nxt && w_cs_nxt && !w_rw_nxt &&
                          (w_cnt_nxt >= c_wr_first) && (w_cnt_nxt <= c_wr_last));
         r_rd_latch  <= w_run_nxt && w_rw_nxt && (w_cnt_nxt == c_last);
         r_cycle_end <= w_run_nxt && (w_cnt_nxt == c_last);
         r_stopped   <= !w_run_nxt;
      end
   end

   assign bus.cphi2     = r_cphi2;
   assign bus.addr_stb  = r_addr_stb;
   assign bus.mem_rdn   = r_mem_rdn;
   assign bus.mem_wrn   = r_mem_wrn;
   assign bus.rd_latch  = r_rd_latch;
   assign bus.cycle_end = r_cycle_end;
   assign bus.stopped   = r_stopped;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_bus_sequencer
//  Description : Self-checking bench for cpu_bus_sequencer (default timing,
//                PERIOD = 8). Directed vector table plus hand-written
//                stop/step/resume sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_sequencer;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_errors = 0;

   cpu_bus_sequencer_if bus ();

   cpu_bus_sequencer #(
      .LOW_TICKS  (4),
      .HIGH_TICKS (4),
      .ADDR_TICK  (2),
      .WR_DLY     (1)
   ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   // Expected field order: {cphi2, addr_stb, mem_rdn, mem_wrn, rd_latch, cycle_end, stopped}
   typedef struct {
      logic       rn;
      logic       stop;
      logic       step;
      logic       rwn;
      logic       cs;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rn, input logic stop, input logic step,
                      input logic rwn, input logic cs, input logic [6:0] exp);
      vec_t v;
      v.rn = rn; v.stop = stop; v.step = step; v.rwn = rwn; v.cs = cs; v.exp = exp;
      vecs.push_back(v);
   endtask

   function automatic logic [6:0] outs();
      return {bus.cphi2, bus.addr_stb, bus.mem_rdn, bus.mem_wrn,
              bus.rd_latch, bus.cycle_end, bus.stopped};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      logic       p_phi, p_rdn;
      int         n_ce, n_phi_tr, n_rdn_tr;
      bit         got_stop;

      resetn       = 1'b0;
      bus.stop_req = 1'b0;
      bus.step_req = 1'b0;
      bus.cpu_rwn  = 1'b1;
      bus.cs_en    = 1'b0;

      // Reset: two edges held in reset
      add(0,0,0,1,0, 7'b0011000);
      add(0,0,0,1,0, 7'b0011000);
      // Free run, read without chip-select: cnt 1..7,0
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b0111000);
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b1011000);
      add(1,0,0,1,0, 7'b1011000);
      add(1,0,0,1,0, 7'b1011000);
      add(1,0,0,1,0, 7'b1011110);
      add(1,0,0,1,0, 7'b0011000);
      // Read with chip-select
      add(1,0,0,1,1, 7'b0011000);
      add(1,0,0,1,1, 7'b0111000);
      add(1,0,0,1,1, 7'b0001000);
      add(1,0,0,1,1, 7'b1001000);
      add(1,0,0,1,1, 7'b1001000);
      add(1,0,0,1,1, 7'b1001000);
      add(1,0,0,1,1, 7'b1001110);
      add(1,0,0,1,1, 7'b0011000);
      // Write with chip-select; cpu_rwn flips back to 1 from cnt 4 on
      add(1,0,0,0,1, 7'b0011000);
      add(1,0,0,0,1, 7'b0111000);
      add(1,0,0,0,1, 7'b0011000);
      add(1,0,0,1,1, 7'b1011000);
      add(1,0,0,1,1, 7'b1010000);
      add(1,0,0,1,1, 7'b1010000);
      add(1,0,0,1,1, 7'b1011010);
      add(1,0,0,1,1, 7'b0011000);
      // stop_req raised at cnt 3: cycle completes, then STOP
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b0111000);
      add(1,1,0,1,0, 7'b0011000);
      add(1,1,0,1,0, 7'b1011000);
      add(1,1,0,1,0, 7'b1011000);
      add(1,1,0,1,0, 7'b1011000);
      add(1,1,0,1,0, 7'b1011110);
      add(1,1,0,1,0, 7'b0011001);
      add(1,1,0,1,0, 7'b0011001);
      // Single step; a step pulse at cnt 5 while running is ignored
      add(1,1,1,1,0, 7'b0011000);
      add(1,1,0,1,0, 7'b0011000);
      add(1,1,0,1,0, 7'b0111000);
      add(1,1,0,1,0, 7'b0011000);
      add(1,1,0,1,0, 7'b1011000);
      add(1,1,1,1,0, 7'b1011000);
      add(1,1,0,1,0, 7'b1011000);
      add(1,1,0,1,0, 7'b1011110);
      add(1,1,0,1,0, 7'b0011001);
      add(1,1,0,1,0, 7'b0011001);
      // Resume: PHI2 rises 4 clks after the RUN entry
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b0111000);
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b1011000);
      add(1,0,0,1,0, 7'b1011000);
      add(1,0,0,1,0, 7'b1011000);
      add(1,0,0,1,0, 7'b1011110);
      add(1,0,0,1,0, 7'b0011000);
      // Write interrupted by reset at cnt 5
      add(1,0,0,0,1, 7'b0011000);
      add(1,0,0,0,1, 7'b0111000);
      add(1,0,0,0,1, 7'b0011000);
      add(1,0,0,0,1, 7'b1011000);
      add(1,0,0,0,1, 7'b1010000);
      add(0,0,0,0,1, 7'b0011000);
      add(1,0,0,1,0, 7'b0011000);
      add(1,0,0,1,0, 7'b0111000);
      add(1,0,0,1,0, 7'b0011000);

      foreach (vecs[i]) begin
         resetn       = vecs[i].rn;
         bus.stop_req = vecs[i].stop;
         bus.step_req = vecs[i].step;
         bus.cpu_rwn  = vecs[i].rwn;
         bus.cs_en    = vecs[i].cs;
         @(posedge clk);
         #1;
         n_checks++;
         if (outs() !== vecs[i].exp) begin
            n_errors++;
            $display("FAIL vec%0d: got %b expected %b", i, outs(), vecs[i].exp);
         end
      end

      // Now in RUN at cnt 3. Request stop and wait (bounded) for it.
      bus.stop_req = 1'b1;
      got_stop = 1'b0;
      for (int k = 0; k < 20 && !got_stop; k++) begin
         @(posedge clk);
         #1;
         if (bus.stopped) got_stop = 1'b1;
      end
      check("stop_reached", int'(got_stop), 1);

      // stop_req low and step_req high together: normal resume, not one step
      bus.cpu_rwn  = 1'b1;
      bus.cs_en    = 1'b1;
      bus.stop_req = 1'b0;
      bus.step_req = 1'b1;
      @(posedge clk);
      #1;
      bus.step_req = 1'b0;
      check("resume_stopped", int'(bus.stopped), 0);
      p_phi = bus.cphi2;
      p_rdn = bus.mem_rdn;
      n_ce = 0; n_phi_tr = 0; n_rdn_tr = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         #1;
         if (bus.cycle_end) n_ce++;
         if (bus.cphi2 != p_phi) n_phi_tr++;
         if (bus.mem_rdn != p_rdn) n_rdn_tr++;
         p_phi = bus.cphi2;
         p_rdn = bus.mem_rdn;
      end
      check("resume_cycle_ends", n_ce, 2);
      check("phi2_transitions", n_phi_tr, 4);
      check("rdn_transitions", n_rdn_tr, 4);
      check("still_running", int'(bus.stopped), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
